// File: rtl/btn_event_decoder.sv
// Turns the debounced button level into one-cycle short, long and double press pulses.
// A single counter times both the long-hold threshold and the double-press release window.
module btn_event_decoder #(
  parameter int unsigned LONG_DELAY = 32'd64000000,
  parameter int unsigned DOUBLE_GAP = 32'd19200000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic double_press
);

  localparam int unsigned MAX_DELAY = (LONG_DELAY > DOUBLE_GAP) ? LONG_DELAY : DOUBLE_GAP;
  localparam int unsigned CNT_W     = $clog2(MAX_DELAY + 32'd1);
  localparam logic [CNT_W-1:0] LONG_TC  = CNT_W'(LONG_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(DOUBLE_GAP - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_GAP     = 2'd2,
    ST_HELD    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             din_q_r;
  logic             din_qq_r;
  logic             rise_s;
  logic             fall_s;
  logic             short_s;
  logic             long_s;
  logic             double_s;
  logic             double_pend_r;

  // Input pipeline; during reset both stages track din so a held button makes no rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q_r  <= din;
      din_qq_r <= din;
      pressed  <= 1'b0;
    end else begin
      din_q_r  <= din;
      din_qq_r <= din_q_r;
      pressed  <= din;
    end
  end

  assign rise_s = din_q_r & ~din_qq_r;
  assign fall_s = ~din_q_r & din_qq_r;

  // Next-state and event decode; a release beats the long timeout, a re-press beats the gap timeout.
  always_comb begin
    state_s  = state_r;
    short_s  = 1'b0;
    long_s   = 1'b0;
    double_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s = ST_PRESSED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (fall_s) begin
          state_s = ST_GAP;
        end else if (cnt_r == LONG_TC) begin
          long_s  = 1'b1;
          state_s = ST_HELD;
        end else begin
          state_s = ST_PRESSED;
        end
      end
      ST_GAP: begin
        if (rise_s) begin
          double_s = 1'b1;
          state_s  = ST_HELD;
        end else if (cnt_r == GAP_TC) begin
          short_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_HELD: begin
        if (!din_q_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HELD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Shared timeout counter: restarts on any state change, runs only while timing a press or gap.
  always_comb begin
    cnt_s = CNT_ZERO;
    if (state_s != state_r) begin
      cnt_s = CNT_ZERO;
    end else if ((state_r == ST_PRESSED) || (state_r == ST_GAP)) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = CNT_ZERO;
    end
  end

  // State, counter and registered event pulses; double press is staged one extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_pend_r <= 1'b0;
      double_press  <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      short_press   <= short_s;
      long_press    <= long_s;
      double_pend_r <= double_s;
      double_press  <= double_pend_r;
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomized and directed bench for btn_event_decoder; expected pulses come from
// press/release timestamps computed from the button level sequence.
module tb_btn_event_decoder;

  localparam int L    = 100;
  localparam int G    = 50;
  localparam int TAIL = L + G + 20;

  logic tb_clk = 1'b0;
  logic rst;
  logic din;
  logic pressed;
  logic short_press;
  logic long_press;
  logic double_press;

  int vectors     = 0;
  int miscompares = 0;

  int         runs_q[$];
  bit         s_q[$];
  logic [3:0] cap_q[$];
  logic [3:0] exp_q[$];

  btn_event_decoder #(.LONG_DELAY(L), .DOUBLE_GAP(G)) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .din          (din),
    .pressed      (pressed),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press)
  );

  always #5 tb_clk = ~tb_clk;

  // Alternating run lengths starting with a press, followed by a long released tail.
  task automatic build_levels();
    bit lvl;
    s_q.delete();
    lvl = 1'b1;
    foreach (runs_q[i]) begin
      repeat (runs_q[i]) s_q.push_back(lvl);
      lvl = ~lvl;
    end
    repeat (TAIL) s_q.push_back(1'b0);
  endtask

  // Drives s_q one level per edge and captures {pressed, short, long, double} just after each edge.
  task automatic apply(input int rst_at);
    cap_q.delete();
    for (int n = 0; n < s_q.size(); n++) begin
      din = s_q[n];
      rst = (n == rst_at);
      @(posedge tb_clk);
      #1;
      cap_q.push_back({pressed, short_press, long_press, double_press});
    end
    rst = 1'b0;
    din = 1'b0;
  endtask

  // Reference: from press start k and release j, long at k+1+L when held > L cycles,
  // double at k2+2 when the next press comes within G released cycles, else short at j+1+G.
  task automatic model(input int rst_at);
    int ks[$];
    int js[$];
    bit prev;
    int i;
    int e;
    exp_q.delete();
    prev = 1'b0;
    foreach (s_q[n]) begin
      exp_q.push_back({(n == rst_at) ? 1'b0 : s_q[n], 3'b000});
      if (s_q[n] && !prev) ks.push_back(n);
      if (!s_q[n] && prev) js.push_back(n);
      prev = s_q[n];
    end
    if (rst_at >= 0) return;
    i = 0;
    while (i < ks.size()) begin
      if (js[i] - ks[i] > L) begin
        e = ks[i] + 1 + L;
        if (e < exp_q.size()) exp_q[e] = exp_q[e] | 4'b0010;
        i = i + 1;
      end else if ((i + 1 < ks.size()) && (ks[i+1] - js[i] <= G)) begin
        e = ks[i+1] + 2;
        if (e < exp_q.size()) exp_q[e] = exp_q[e] | 4'b0001;
        i = i + 2;
      end else begin
        e = js[i] + 1 + G;
        if (e < exp_q.size()) exp_q[e] = exp_q[e] | 4'b0100;
        i = i + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    repeat (3) begin
      @(posedge tb_clk);
      #1;
      vectors++;
      if ({pressed, short_press, long_press, double_press} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold got %b want 0000", {pressed, short_press, long_press, double_press});
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge tb_clk);
      #1;
      vectors++;
      if ({pressed, short_press, long_press, double_press} !== 4'b1000) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL reset_held_button n=%0d got %b want 1000", n, {pressed, short_press, long_press, double_press});
      end
    end
    din = 1'b0;
    for (int n = 0; n < TAIL; n++) begin
      @(posedge tb_clk);
      #1;
      vectors++;
      if ({pressed, short_press, long_press, double_press} !== 4'b0000) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL reset_release n=%0d got %b want 0000", n, {pressed, short_press, long_press, double_press});
      end
    end
  endtask

  task automatic test_short();
    int pos;
    runs_q = '{20};
    build_levels();
    apply(-1);
    model(-1);
    pos = -1;
    foreach (cap_q[n]) begin
      vectors++;
      if (cap_q[n] !== exp_q[n]) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL short n=%0d got %b want %b", n, cap_q[n], exp_q[n]);
      end
      if (cap_q[n][2] && pos < 0) pos = n;
    end
    vectors++;
    if (pos !== 71) begin
      miscompares++;
      $display("FAIL short_latency got edge %0d want edge 71", pos);
    end
  endtask

  task automatic test_long();
    int pos;
    runs_q = '{300};
    build_levels();
    apply(-1);
    model(-1);
    pos = -1;
    foreach (cap_q[n]) begin
      vectors++;
      if (cap_q[n] !== exp_q[n]) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL long n=%0d got %b want %b", n, cap_q[n], exp_q[n]);
      end
      if (cap_q[n][1] && pos < 0) pos = n;
    end
    vectors++;
    if (pos !== 101) begin
      miscompares++;
      $display("FAIL long_latency got edge %0d want edge 101", pos);
    end
  endtask

  task automatic test_double();
    int pos;
    runs_q = '{20, 30, 20};
    build_levels();
    apply(-1);
    model(-1);
    pos = -1;
    foreach (cap_q[n]) begin
      vectors++;
      if (cap_q[n] !== exp_q[n]) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL double n=%0d got %b want %b", n, cap_q[n], exp_q[n]);
      end
      if (cap_q[n][0] && pos < 0) pos = n;
    end
    vectors++;
    if (pos !== 52) begin
      miscompares++;
      $display("FAIL double_latency got edge %0d want edge 52", pos);
    end
  endtask

  task automatic test_boundaries();
    int nshort;
    int nlong;
    // Release on the long terminal count, then re-press on the gap terminal count.
    runs_q = '{L, TAIL, 20, G, 20};
    build_levels();
    apply(-1);
    model(-1);
    nlong = 0;
    foreach (cap_q[n]) begin
      vectors++;
      if (cap_q[n] !== exp_q[n]) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL boundary_tc n=%0d got %b want %b", n, cap_q[n], exp_q[n]);
      end
      if (cap_q[n][1]) nlong++;
    end
    vectors++;
    if (nlong !== 0) begin
      miscompares++;
      $display("FAIL boundary_no_long got %0d long pulses want 0", nlong);
    end
    // Second press one cycle past the double window: two separate short presses.
    runs_q = '{20, G + 1, 20};
    build_levels();
    apply(-1);
    model(-1);
    nshort = 0;
    foreach (cap_q[n]) begin
      vectors++;
      if (cap_q[n] !== exp_q[n]) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL boundary_fresh n=%0d got %b want %b", n, cap_q[n], exp_q[n]);
      end
      if (cap_q[n][2]) nshort++;
    end
    vectors++;
    if (nshort !== 2) begin
      miscompares++;
      $display("FAIL boundary_two_shorts got %0d short pulses want 2", nshort);
    end
  endtask

  task automatic test_mid_reset();
    // Reset hits at PRESSED cnt=60 (held press) and at GAP cnt=40 (20-cycle press).
    for (int t = 0; t < 2; t++) begin
      runs_q = (t == 0) ? '{200} : '{20};
      build_levels();
      apply(62);
      model(62);
      foreach (cap_q[n]) begin
        vectors++;
        if (cap_q[n] !== exp_q[n]) begin
          miscompares++;
          if (miscompares <= 20) $display("FAIL mid_reset%0d n=%0d got %b want %b", t, n, cap_q[n], exp_q[n]);
        end
      end
    end
    runs_q = '{20};
    build_levels();
    apply(-1);
    model(-1);
    foreach (cap_q[n]) begin
      vectors++;
      if (cap_q[n] !== exp_q[n]) begin
        miscompares++;
        if (miscompares <= 20) $display("FAIL after_reset n=%0d got %b want %b", n, cap_q[n], exp_q[n]);
      end
    end
  endtask

  task automatic test_random();
    int np;
    for (int s = 0; s < 12; s++) begin
      runs_q.delete();
      np = $urandom_range(4, 1);
      for (int p = 0; p < np; p++) begin
        case ($urandom_range(3, 0))
          0:       runs_q.push_back(L);
          1:       runs_q.push_back(L + 1);
          2:       runs_q.push_back($urandom_range(L - 1, 1));
          default: runs_q.push_back($urandom_range(L + 30, L + 2));
        endcase
        if (p < np - 1) begin
          case ($urandom_range(3, 0))
            0:       runs_q.push_back(G);
            1:       runs_q.push_back(G + 1);
            2:       runs_q.push_back($urandom_range(G - 1, 1));
            default: runs_q.push_back($urandom_range(G + 30, G + 2));
          endcase
        end
      end
      build_levels();
      apply(-1);
      model(-1);
      foreach (cap_q[n]) begin
        vectors++;
        if (cap_q[n] !== exp_q[n]) begin
          miscompares++;
          if (miscompares <= 20) $display("FAIL random seq=%0d n=%0d got %b want %b", s, n, cap_q[n], exp_q[n]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b1;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundaries();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
